// File: rtl/cov_outer_product.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cov_outer_product : centred 4-channel outer product, one shared multiplier
// Revision 1.0
// ============================================================================
module cov_outer_product #(
  parameter int N_SAMPLES = 128,
  parameter int FRAC      = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mu1,
  input  logic [15:0] mu2,
  input  logic [15:0] mu3,
  input  logic [15:0] mu4,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic [15:0] x3,
  input  logic [15:0] x4,
  output logic [15:0] X1X1,
  output logic [15:0] X1X2,
  output logic [15:0] X1X3,
  output logic [15:0] X1X4,
  output logic [15:0] X2X2,
  output logic [15:0] X2X3,
  output logic [15:0] X2X4,
  output logic [15:0] X3X3,
  output logic [15:0] X3X4,
  output logic [15:0] X4X4,
  output logic        out_valid,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(N_SAMPLES) + 1;
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(N_SAMPLES);
  localparam logic [3:0]    C_IDX_LAST = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic signed [15:0] r_mu     [4];
  logic signed [15:0] r_d      [4];
  logic signed [15:0] r_shadow [9];
  logic signed [15:0] r_xo     [10];
  logic [3:0]         r_idx;
  logic [CW-1:0]      r_cnt;

  logic [15:0]        w_x   [4];
  logic [15:0]        w_mu  [4];
  logic signed [15:0] w_a, w_b;
  logic signed [31:0] w_prod, w_shift;
  logic signed [15:0] w_prod_sat;
  logic [CW-1:0]      w_cnt_inc;

  assign w_x  = '{x1, x2, x3, x4};
  assign w_mu = '{mu1, mu2, mu3, mu4};
  assign w_cnt_inc = r_cnt + C_CNT_ONE;

  // 17-bit difference so that the full x - mu range is representable before clamping
  function automatic logic signed [15:0] sat_diff(input logic [15:0] x, input logic [15:0] mu);
    logic signed [16:0] diff;
    diff = $signed({x[15], x}) - $signed({mu[15], mu});
    if (diff > 17'sd32767)
      return 16'sh7fff;
    else if (diff < -17'sd32768)
      return 16'sh8000;
    else
      return diff[15:0];
  endfunction

  // Operand pair for the upper triangle, row-major: 11,12,13,14,22,23,24,33,34,44
  always_comb begin
    w_a = r_d[3];
    w_b = r_d[3];
    case (r_idx)
      4'd0:    begin w_a = r_d[0]; w_b = r_d[0]; end
      4'd1:    begin w_a = r_d[0]; w_b = r_d[1]; end
      4'd2:    begin w_a = r_d[0]; w_b = r_d[2]; end
      4'd3:    begin w_a = r_d[0]; w_b = r_d[3]; end
      4'd4:    begin w_a = r_d[1]; w_b = r_d[1]; end
      4'd5:    begin w_a = r_d[1]; w_b = r_d[2]; end
      4'd6:    begin w_a = r_d[1]; w_b = r_d[3]; end
      4'd7:    begin w_a = r_d[2]; w_b = r_d[2]; end
      4'd8:    begin w_a = r_d[2]; w_b = r_d[3]; end
      default: begin w_a = r_d[3]; w_b = r_d[3]; end
    endcase
  end

  always_comb begin
    w_prod  = w_a * w_b;
    w_shift = w_prod >>> FRAC;
    if (w_shift > 32'sd32767)
      w_prod_sat = 16'sh7fff;
    else if (w_shift < -32'sd32768)
      w_prod_sat = 16'sh8000;
    else
      w_prod_sat = w_shift[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) w_next = S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (r_idx == C_IDX_LAST) w_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        w_next    = (w_cnt_inc == C_CNT_LAST) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        r_mu[i] <= '0;
        r_d[i]  <= '0;
      end
      for (int k = 0; k < 9; k++) r_shadow[k] <= '0;
      for (int k = 0; k < 10; k++) r_xo[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 4; i++) r_mu[i] <= w_mu[i];
            r_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < 4; i++) r_d[i] <= sat_diff(w_x[i], r_mu[i]);
            r_idx <= '0;
          end
        end
        S_MUL: begin
          for (int k = 0; k < 9; k++)
            if (r_idx == 4'(k)) r_shadow[k] <= w_prod_sat;
          // Last product bypasses the shadow so all ten outputs change on OUT entry
          if (r_idx == C_IDX_LAST) begin
            for (int k = 0; k < 9; k++) r_xo[k] <= r_shadow[k];
            r_xo[9] <= w_prod_sat;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_OUT: r_cnt <= w_cnt_inc;
        default: ;
      endcase
    end
  end

  assign X1X1 = r_xo[0];
  assign X1X2 = r_xo[1];
  assign X1X3 = r_xo[2];
  assign X1X4 = r_xo[3];
  assign X2X2 = r_xo[4];
  assign X2X3 = r_xo[5];
  assign X2X4 = r_xo[6];
  assign X3X3 = r_xo[7];
  assign X3X4 = r_xo[8];
  assign X4X4 = r_xo[9];

endmodule
`default_nettype wire

// File: tb/tb_cov_outer_product.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for cov_outer_product: directed steps with random samples against an arithmetic model.
module tb_cov_outer_product;

  localparam int N  = 128;
  localparam int FR = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] mu1 = '0, mu2 = '0, mu3 = '0, mu4 = '0;
  logic [15:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  wire         in_ready, out_valid, busy, frame_done;
  wire  [15:0] X1X1, X1X2, X1X3, X1X4, X2X2, X2X3, X2X4, X3X3, X3X4, X4X4;
  wire [159:0] dut_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [159:0] last_exp = '0;
  logic [63:0]  mu_m = '0;

  cov_outer_product #(.N_SAMPLES(N), .FRAC(FR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mu1(mu1), .mu2(mu2), .mu3(mu3), .mu4(mu4),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .X1X1(X1X1), .X1X2(X1X2), .X1X3(X1X3), .X1X4(X1X4), .X2X2(X2X2),
    .X2X3(X2X3), .X2X4(X2X4), .X3X3(X3X3), .X3X4(X3X4), .X4X4(X4X4),
    .out_valid(out_valid), .busy(busy), .frame_done(frame_done)
  );

  assign dut_out = {X4X4, X3X4, X3X3, X2X4, X2X3, X2X2, X1X4, X1X3, X1X2, X1X1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Slot k of the result holds the k-th pair (a<=b) in row-major order
  function automatic logic [159:0] model(input logic [63:0] xs, input logic [63:0] ms);
    int d[4];
    int k;
    logic [159:0] r;
    r = '0;
    k = 0;
    for (int i = 0; i < 4; i++)
      d[i] = sat(int'($signed(xs[16*i +: 16])) - int'($signed(ms[16*i +: 16])));
    for (int a = 0; a < 4; a++)
      for (int b = a; b < 4; b++) begin
        r[16*k +: 16] = 16'(sat((d[a] * d[b]) >>> FR));
        k++;
      end
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input logic [63:0] v);
    {x4, x3, x2, x1} = v;
  endtask

  task automatic set_mu(input logic [63:0] v);
    {mu4, mu3, mu2, mu1} = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("reset_outputs", dut_out, '0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [63:0] m);
    set_mu(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    mu_m = m;
    chk("busy_after_start", busy, 1);
    chk("ready_in_load", in_ready, 1);
  endtask

  // Streams n samples with in_valid held high; optional start pulse with fresh means mid-way
  task automatic stream(input int n, input logic [63:0] first_x, input bit use_first,
                        input int pulse_at, input bit expect_done);
    logic [159:0] q_exp[$];
    int           q_cyc[$];
    int           sent, got, last_ov, fd_seen, iters;
    bit           r, v;
    logic [63:0]  cur_x;
    sent = 0; got = 0; last_ov = -1; fd_seen = 0; iters = 0;
    cur_x = use_first ? first_x : rnd64();
    set_x(cur_x);
    in_valid = 1'b1;
    while (got < n && iters < n * 12 + 40) begin
      if (pulse_at >= 0 && sent == pulse_at) begin
        start = 1'b1;
        set_mu(rnd64());
      end else begin
        start = 1'b0;
      end
      r = in_ready;
      v = in_valid;
      tick();
      iters++;
      if (r && v) begin
        q_exp.push_back(model(cur_x, mu_m));
        q_cyc.push_back(cyc - 1);
        sent++;
        if (sent == n) in_valid = 1'b0;
        else begin
          cur_x = rnd64();
          set_x(cur_x);
        end
      end
      if (frame_done) fd_seen++;
      if (out_valid) begin
        if (q_exp.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          last_exp = q_exp.pop_front();
          chk("products", dut_out, last_exp);
          chk("latency", cyc - q_cyc.pop_front(), 11);
          if (last_ov >= 0) chk("spacing", cyc - last_ov, 12);
          last_ov = cyc;
          got++;
        end
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("stream_complete", got, n);
    chk("no_early_frame_done", fd_seen, 0);
    if (expect_done) begin
      tick();
      chk("frame_done_strobe", frame_done, 1);
      chk("busy_low_at_done", busy, 0);
      chk("ready_low_at_done", in_ready, 0);
      tick();
      chk("frame_done_one_cycle", frame_done, 0);
      chk("ready_low_after_frame", in_ready, 0);
      chk("busy_low_after_frame", busy, 0);
    end
  endtask

  initial begin
    logic [63:0] tmp;
    int act;

    do_reset();

    // Sample offered before any start must be ignored
    in_valid = 1'b1;
    set_x(rnd64());
    repeat (4) begin
      tick();
      chk("ready_low_idle", in_ready, 0);
      chk("no_out_idle", out_valid, 0);
    end
    in_valid = 1'b0;

    // Basic products with zero means: x = (8192, 4096, -4096, 0)
    do_start('0);
    stream(1, {16'h0000, 16'hF000, 16'h1000, 16'h2000}, 1'b1, -1, 1'b0);
    chk("basic_x1x1", X1X1, 16'd16384);
    chk("basic_x1x2", X1X2, 16'd8192);
    chk("basic_x1x3", X1X3, 16'hE000);
    chk("basic_x2x2", X2X2, 16'd4096);
    chk("basic_x2x3", X2X3, 16'hF000);
    chk("basic_x3x3", X3X3, 16'd4096);
    chk("basic_zero_x4", {X1X4, X2X4, X3X4, X4X4}, '0);
    repeat (5) tick();
    chk("outputs_hold", dut_out, last_exp);

    // Rest of the frame back-to-back, with an ignored start pulse mid-frame
    stream(N - 1, '0, 1'b0, 40, 1'b1);
    chk("outputs_hold_idle", dut_out, last_exp);

    // Reset at product index 5
    do_start(rnd64());
    set_x(rnd64());
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midmul_rst_outputs", dut_out, '0);
    chk("midmul_rst_out_valid", out_valid, 0);
    chk("midmul_rst_busy", busy, 0);
    chk("midmul_rst_in_ready", in_ready, 0);
    chk("midmul_rst_frame_done", frame_done, 0);
    rst = 1'b0;
    act = 0;
    repeat (15) begin
      tick();
      act += int'(out_valid) + int'(frame_done) + int'(busy);
    end
    chk("no_activity_after_rst", act, 0);

    // Centring saturation: mu1 = -32768, x1 = 32767
    tmp = rnd64();
    tmp[15:0] = 16'h8000;
    do_start(tmp);
    tmp = rnd64();
    tmp[15:0] = 16'h7FFF;
    stream(1, tmp, 1'b1, -1, 1'b0);
    chk("sat_centre_x1x1", X1X1, 16'h7FFF);

    // Product saturation: mu1 = 0, x1 = -32768
    do_reset();
    do_start('0);
    tmp = rnd64();
    tmp[15:0] = 16'h8000;
    stream(1, tmp, 1'b1, -1, 1'b0);
    chk("sat_square_x1x1", X1X1, 16'h7FFF);

    // More random samples within the same frame
    stream(20, '0, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
